// File: rtl/ddr2_init_seq.sv
// ============================================================================
// ddr2_init_seq
//
// DDR2 power-up / initialization sequencer. Owns CKE and the command/address
// pins of the DIMM from reset until init_done. It replays the JEDEC DDR2 init
// sequence and then hands the bus to the main scheduler:
//
//   CKE low (T_INIT_CYC) -> CKE high + NOP (T_CKE_CYC) -> PRE-ALL -> EMRS2 ->
//   EMRS3 -> EMRS1 -> MRS (DLL reset) -> PRE-ALL -> REF -> REF -> MRS ->
//   [OCD default -> OCD exit] -> DLL lock wait (T_DLL_CYC) -> init_done
//
// Optional feature (compile-time macro):
//   DDR2_OCD_EN - when defined, two EMRS1 writes (OCD calibration default,
//                 then OCD exit) are inserted after the final MRS.
//
// Ports:
//   clk        in   controller clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   level; begins the sequence when sampled high in IDLE
//   cke        out  DRAM clock enable
//   cs_n       out  chip select
//   ras_n      out  row address strobe
//   cas_n      out  column address strobe
//   we_n       out  write enable
//   ba         out  bank address   [BA_WIDTH-1:0]
//   addr       out  address        [ADDR_WIDTH-1:0]
//   busy       out  high from start acceptance until init_done
//   init_done  out  sticky completion flag (cleared only by reset)
//
// All outputs come straight from flops.
// ============================================================================
module ddr2_init_seq #(
    parameter int BA_WIDTH    = 3,
    parameter int ADDR_WIDTH  = 14,
    parameter int CAS_LATENCY = 5,
    parameter int WR_FIELD    = 5,
    parameter int EMR1_VAL    = 'h400,
    parameter int T_INIT_CYC  = 40000,
    parameter int T_CKE_CYC   = 80,
    parameter int T_RP_CYC    = 4,
    parameter int T_MRD_CYC   = 2,
    parameter int T_RFC_CYC   = 26,
    parameter int T_DLL_CYC   = 200
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  cke,
    output logic                  cs_n,
    output logic                  ras_n,
    output logic                  cas_n,
    output logic                  we_n,
    output logic [BA_WIDTH-1:0]   ba,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  busy,
    output logic                  init_done
);

    // ------------------------------------------------------------------------
    // Counter sizing: wide enough to hold the largest (T_x - 1) load value.
    // ------------------------------------------------------------------------
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_INIT_CYC, T_CKE_CYC),
                                     max2(T_RP_CYC, T_MRD_CYC)),
                                max2(T_RFC_CYC, T_DLL_CYC));
    localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    // Load value for a spacing of t cycles. A spacing of 0 is not meaningful
    // and is treated like 1 (advance on the very next cycle).
    function automatic logic [CNT_W-1:0] ld(input int t);
        return (t <= 1) ? '0 : CNT_W'(t - 1);
    endfunction

    // ------------------------------------------------------------------------
    // Command encodings {cs_n, ras_n, cas_n, we_n}
    // ------------------------------------------------------------------------
    localparam logic [3:0] CMD_DES = 4'b1111;  // deselect, used while CKE is low
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    // ------------------------------------------------------------------------
    // Mode-register images. Everything above bit 12 is forced to zero.
    // MR layout: [12]=PD(0) [11:9]=WR [8]=DLL reset [7]=TM [6:4]=CL [3]=BT [2:0]=BL
    // ------------------------------------------------------------------------
    localparam logic [12:0] MR_DLL_13 = {1'b0, 3'(WR_FIELD), 1'b1, 1'b0,
                                         3'(CAS_LATENCY), 1'b0, 3'd2};
    localparam logic [12:0] MR_RUN_13 = {1'b0, 3'(WR_FIELD), 1'b0, 1'b0,
                                         3'(CAS_LATENCY), 1'b0, 3'd2};

    localparam logic [ADDR_WIDTH-1:0] ADDR_A10 = ADDR_WIDTH'(13'h0400);
    localparam logic [ADDR_WIDTH-1:0] MR_DLL   = ADDR_WIDTH'(MR_DLL_13);
    localparam logic [ADDR_WIDTH-1:0] MR_RUN   = ADDR_WIDTH'(MR_RUN_13);
    localparam logic [ADDR_WIDTH-1:0] EMR1     = ADDR_WIDTH'(13'(EMR1_VAL));
`ifdef DDR2_OCD_EN
    // OCD calibration default: EMR1[9:7] = 3'b111
    localparam logic [ADDR_WIDTH-1:0] EMR1_OCD = ADDR_WIDTH'(13'(EMR1_VAL) | 13'h0380);
`endif

    localparam logic [BA_WIDTH-1:0] BA_MR   = BA_WIDTH'(0);
    localparam logic [BA_WIDTH-1:0] BA_EMR1 = BA_WIDTH'(1);
    localparam logic [BA_WIDTH-1:0] BA_EMR2 = BA_WIDTH'(2);
    localparam logic [BA_WIDTH-1:0] BA_EMR3 = BA_WIDTH'(3);

    // ------------------------------------------------------------------------
    // State encoding. Apart from IDLE/PWR/CKE/WAIT_DLL/DONE, each state is
    // named after the command that was just issued; the state is held while
    // the counter runs out that command's spacing, and the cycle it sees
    // cnt==0 is the cycle it issues the next command.
    // ------------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_PWR      = 4'd1,
        S_CKE      = 4'd2,
        S_PRE1     = 4'd3,
        S_EMRS2    = 4'd4,
        S_EMRS3    = 4'd5,
        S_EMRS1    = 4'd6,
        S_MRS_DLL  = 4'd7,
        S_PRE2     = 4'd8,
        S_REF1     = 4'd9,
        S_REF2     = 4'd10,
        S_MRS      = 4'd11,
        S_OCD_DEF  = 4'd12,
        S_WAIT_DLL = 4'd13,
        S_DONE     = 4'd14
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    cke_q;
    logic [3:0]              cmd_q;
    logic [BA_WIDTH-1:0]     ba_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    busy_q;
    logic                    done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cke_q   <= 1'b0;
            cmd_q   <= CMD_DES;
            ba_q    <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // Between commands: deselect while CKE is low, NOP once it is high.
            // Bank/address are parked at zero whenever no command is driven.
            cmd_q  <= cke_q ? CMD_NOP : CMD_DES;
            ba_q   <= '0;
            addr_q <= '0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        state_q <= S_PWR;
                        cnt_q   <= ld(T_INIT_CYC);
                    end
                end

                // Terminal: CKE high, NOP held, start ignored until reset.
                S_DONE: begin
                end

                default: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        case (state_q)
                            S_PWR: begin
                                cke_q   <= 1'b1;
                                cmd_q   <= CMD_NOP;
                                state_q <= S_CKE;
                                cnt_q   <= ld(T_CKE_CYC);
                            end
                            S_CKE: begin
                                cmd_q   <= CMD_PRE;
                                addr_q  <= ADDR_A10;
                                state_q <= S_PRE1;
                                cnt_q   <= ld(T_RP_CYC);
                            end
                            S_PRE1: begin
                                cmd_q   <= CMD_MRS;
                                ba_q    <= BA_EMR2;
                                state_q <= S_EMRS2;
                                cnt_q   <= ld(T_MRD_CYC);
                            end
                            S_EMRS2: begin
                                cmd_q   <= CMD_MRS;
                                ba_q    <= BA_EMR3;
                                state_q <= S_EMRS3;
                                cnt_q   <= ld(T_MRD_CYC);
                            end
                            S_EMRS3: begin
                                cmd_q   <= CMD_MRS;
                                ba_q    <= BA_EMR1;
                                addr_q  <= EMR1;
                                state_q <= S_EMRS1;
                                cnt_q   <= ld(T_MRD_CYC);
                            end
                            S_EMRS1: begin
                                cmd_q   <= CMD_MRS;
                                ba_q    <= BA_MR;
                                addr_q  <= MR_DLL;
                                state_q <= S_MRS_DLL;
                                cnt_q   <= ld(T_MRD_CYC);
                            end
                            S_MRS_DLL: begin
                                cmd_q   <= CMD_PRE;
                                addr_q  <= ADDR_A10;
                                state_q <= S_PRE2;
                                cnt_q   <= ld(T_RP_CYC);
                            end
                            S_PRE2: begin
                                cmd_q   <= CMD_REF;
                                state_q <= S_REF1;
                                cnt_q   <= ld(T_RFC_CYC);
                            end
                            S_REF1: begin
                                cmd_q   <= CMD_REF;
                                state_q <= S_REF2;
                                cnt_q   <= ld(T_RFC_CYC);
                            end
                            S_REF2: begin
                                cmd_q   <= CMD_MRS;
                                ba_q    <= BA_MR;
                                addr_q  <= MR_RUN;
`ifdef DDR2_OCD_EN
                                state_q <= S_MRS;
                                cnt_q   <= ld(T_MRD_CYC);
`else
                                // The DLL lock window is timed from the last
                                // mode-register write; it already spans tMRD.
                                state_q <= S_WAIT_DLL;
                                cnt_q   <= ld(T_DLL_CYC);
`endif
                            end
`ifdef DDR2_OCD_EN
                            S_MRS: begin
                                cmd_q   <= CMD_MRS;
                                ba_q    <= BA_EMR1;
                                addr_q  <= EMR1_OCD;
                                state_q <= S_OCD_DEF;
                                cnt_q   <= ld(T_MRD_CYC);
                            end
                            S_OCD_DEF: begin
                                // OCD exit is the last mode-register write, so
                                // the DLL lock window starts here.
                                cmd_q   <= CMD_MRS;
                                ba_q    <= BA_EMR1;
                                addr_q  <= EMR1;
                                state_q <= S_WAIT_DLL;
                                cnt_q   <= ld(T_DLL_CYC);
                            end
`endif
                            S_WAIT_DLL: begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= S_DONE;
                            end
                            // Unused encodings fall back to a quiet IDLE.
                            default: begin
                                cke_q   <= 1'b0;
                                cmd_q   <= CMD_DES;
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign cke                        = cke_q;
    assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
    assign ba                         = ba_q;
    assign addr                       = addr_q;
    assign busy                       = busy_q;
    assign init_done                  = done_q;

endmodule

// File: tb/tb_ddr2_init_seq.sv
module tb_ddr2_init_seq;

    localparam int BA_W = 3;
    localparam int AD_W = 14;
    localparam int CL   = 5;
    localparam int WR   = 5;
    localparam int EMR1 = 'h400;
    localparam int TI   = 20;
    localparam int TC   = 5;
    localparam int TRP  = 3;
    localparam int TMRD = 2;
    localparam int TRFC = 8;
    localparam int TDLL = 10;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            cke, cs_n, ras_n, cas_n, we_n;
    logic [BA_W-1:0] ba;
    logic [AD_W-1:0] addr;
    logic            busy, init_done;

    ddr2_init_seq #(
        .BA_WIDTH(BA_W), .ADDR_WIDTH(AD_W), .CAS_LATENCY(CL), .WR_FIELD(WR),
        .EMR1_VAL(EMR1), .T_INIT_CYC(TI), .T_CKE_CYC(TC), .T_RP_CYC(TRP),
        .T_MRD_CYC(TMRD), .T_RFC_CYC(TRFC), .T_DLL_CYC(TDLL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cke(cke), .cs_n(cs_n),
        .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr),
        .busy(busy), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference plan: one entry per command after CKE rise, with the spacing
    // to the next event (the last spacing is the DLL lock window).
    typedef struct {
        logic [3:0] cmd;
        int         ba;
        int         addr;
        int         amask;
        int         bmask;
        int         gap;
    } step_t;

    typedef struct {
        int         t;
        logic [3:0] cmd;
        logic [BA_W-1:0] ba;
        logic [AD_W-1:0] addr;
    } ev_t;

    step_t plan[$];
    ev_t   obs_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_plan();
        int mr_dll, mr_run;
        mr_dll = (WR << 9) | (1 << 8) | (CL << 4) | 2;
        mr_run = (WR << 9) | (CL << 4) | 2;
        plan.delete();
        plan.push_back('{C_PRE, 0, 'h400, 'h400, 0, TRP});
        plan.push_back('{C_MRS, 2, 0, 'h3fff, 'h7, TMRD});
        plan.push_back('{C_MRS, 3, 0, 'h3fff, 'h7, TMRD});
        plan.push_back('{C_MRS, 1, EMR1, 'h3fff, 'h7, TMRD});
        plan.push_back('{C_MRS, 0, mr_dll, 'h3fff, 'h7, TMRD});
        plan.push_back('{C_PRE, 0, 'h400, 'h400, 0, TRP});
        plan.push_back('{C_REF, 0, 0, 0, 0, TRFC});
        plan.push_back('{C_REF, 0, 0, 0, 0, TRFC});
`ifdef DDR2_OCD_EN
        plan.push_back('{C_MRS, 0, mr_run, 'h3fff, 'h7, TMRD});
        plan.push_back('{C_MRS, 1, EMR1 | (7 << 7), 'h3fff, 'h7, TMRD});
        plan.push_back('{C_MRS, 1, EMR1, 'h3fff, 'h7, TDLL});
`else
        plan.push_back('{C_MRS, 0, mr_run, 'h3fff, 'h7, TDLL});
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".cke"},   32'(cke), 0);
        chk({tag, ".cmd"},   32'({cs_n, ras_n, cas_n, we_n}), 32'hf);
        chk({tag, ".ba"},    32'(ba), 0);
        chk({tag, ".addr"},  32'(addr), 0);
        chk({tag, ".busy"},  32'(busy), 0);
        chk({tag, ".done"},  32'(init_done), 0);
    endtask

    // Starts a sequence and observes it until init_done (bounded).
    // mode 0: start pulse of len cycles; 1: start held high; 2: random
    // toggling of start after the first len cycles.
    task automatic run_seq(input int len, input int mode, output int ka,
                           output int rise, output int done_t,
                           output int bad_bus, output int busy_bad);
        obs_q.delete();
        rise = -1; done_t = -1; bad_bus = 0; busy_bad = 0;
        @(negedge clk);
        start = 1'b1;
        ka = cyc + 1;
        for (int i = 0; i < 400 && done_t < 0; i++) begin
            @(negedge clk);
            if (cyc - ka >= len - 1) begin
                if (mode == 0) start = 1'b0;
                else if (mode == 2) start = 1'($urandom_range(0, 1));
            end
            if (rise < 0 && cke === 1'b1) rise = cyc;
            if (cke !== 1'b1 && cs_n !== 1'b1) bad_bus++;
            if (cke === 1'b1 && cs_n !== 1'b0) bad_bus++;
            if (cke === 1'b1 && cs_n === 1'b0 && {ras_n, cas_n, we_n} !== 3'b111)
                obs_q.push_back('{cyc, {cs_n, ras_n, cas_n, we_n}, ba, addr});
            if (init_done === 1'b1) begin
                done_t = cyc;
                if (busy !== 1'b0) busy_bad++;
            end else if (busy !== 1'b1) begin
                busy_bad++;
            end
        end
    endtask

    task automatic check_seq(input string tag, input int ka, input int rise,
                             input int done_t, input int bad_bus, input int busy_bad);
        int t_exp;
        chk({tag, ".done_seen"}, 32'(done_t >= 0), 1);
        chk({tag, ".cke_rise"},  32'(rise - ka), 32'(TI));
        chk({tag, ".bus_idle"},  32'(bad_bus), 0);
        chk({tag, ".busy"},      32'(busy_bad), 0);
        chk({tag, ".ncmd"},      32'(obs_q.size()), 32'(plan.size()));
        t_exp = TI + TC;
        for (int i = 0; i < plan.size(); i++) begin
            if (i < obs_q.size()) begin
                chk($sformatf("%s.ev%0d.t", tag, i),   32'(obs_q[i].t - ka), 32'(t_exp));
                chk($sformatf("%s.ev%0d.cmd", tag, i), 32'(obs_q[i].cmd), 32'(plan[i].cmd));
                if (plan[i].bmask != 0)
                    chk($sformatf("%s.ev%0d.ba", tag, i), 32'(obs_q[i].ba), 32'(plan[i].ba));
                if (plan[i].amask != 0)
                    chk($sformatf("%s.ev%0d.addr", tag, i),
                        32'(obs_q[i].addr) & 32'(plan[i].amask),
                        32'(plan[i].addr & plan[i].amask));
            end
            t_exp += plan[i].gap;
        end
        chk({tag, ".done_t"}, 32'(done_t - ka), 32'(t_exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ka, rise, done_t, bad_bus, busy_bad, ncmd, drops, found;

        build_plan();

        // Reset held over 10 clocks; start during reset must not take effect.
        rst_n = 1'b0;
        start = 1'b0;
        ncmd  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cs_n !== 1'b1) ncmd++;
            if (i == 6) start = 1'b1;
        end
        chk("reset.no_cmd", 32'(ncmd), 0);
        check_reset_vals("reset");
        start = 1'b0;
        rst_n = 1'b1;

        repeat ($urandom_range(2, 6)) @(negedge clk);
        chk("idle.busy", 32'(busy), 0);
        chk("idle.cke",  32'(cke), 0);

        // Full sequence with a single-cycle start pulse.
        run_seq(1, 0, ka, rise, done_t, bad_bus, busy_bad);
        check_seq("seq1", ka, rise, done_t, bad_bus, busy_bad);

        // start re-asserted in DONE is ignored; init_done is sticky.
        start = 1'b1;
        ncmd = 0; drops = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 15) start = 1'b0;
            if (cs_n !== 1'b0 || {ras_n, cas_n, we_n} !== 3'b111) ncmd++;
            if (init_done !== 1'b1 || busy !== 1'b0 || cke !== 1'b1) drops++;
        end
        chk("done.no_cmd", 32'(ncmd), 0);
        chk("done.sticky", 32'(drops), 0);

        // Fresh sequence, then asynchronous reset in the middle of the REF1 wait.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk);
            if (cs_n === 1'b0 && {ras_n, cas_n, we_n} === 3'b001) found = 1;
        end
        chk("midref.reached", 32'(found), 1);
        repeat ($urandom_range(1, TRFC - 2)) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midref.async");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat ($urandom_range(3, 8)) @(negedge clk);
        chk("midref.no_restart.busy", 32'(busy), 0);
        chk("midref.no_restart.cke",  32'(cke), 0);
        chk("midref.no_restart.cs_n", 32'(cs_n), 1);

        // Restart with start toggling randomly during the sequence.
        run_seq($urandom_range(1, 4), 2, ka, rise, done_t, bad_bus, busy_bad);
        check_seq("seq2", ka, rise, done_t, bad_bus, busy_bad);
        start = 1'b0;

        // start held high throughout: exactly one sequence.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        run_seq(1, 1, ka, rise, done_t, bad_bus, busy_bad);
        check_seq("seq3", ka, rise, done_t, bad_bus, busy_bad);
        ncmd = 0; drops = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 20) start = 1'b0;
            if (i == 30) start = 1'b1;
            if (cs_n !== 1'b0 || {ras_n, cas_n, we_n} !== 3'b111) ncmd++;
            if (init_done !== 1'b1 || busy !== 1'b0) drops++;
        end
        start = 1'b0;
        chk("hold.no_cmd", 32'(ncmd), 0);
        chk("hold.sticky", 32'(drops), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
